regfile_wb_scheduler: RTL and testbench

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_wb_scheduler.sv | 137 +++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler.
// Two writeback sources (ALU and load unit) share one register-file write
// port. Ties between them are broken round-robin. A busy scoreboard tracks
// registers with a pending writeback and gates instruction issue.
module regfile_wb_scheduler #(
  parameter int index_width = 3,
  parameter int reg_width   = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  // ALU writeback requester
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [index_width-1:0]       a_idx,
  input  logic [reg_width-1:0]         a_data,
  // load-unit writeback requester
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic [index_width-1:0]       m_idx,
  input  logic [reg_width-1:0]         m_data,
  // issue check
  input  logic                         iss_valid,
  input  logic [index_width-1:0]       iss_rd,
  input  logic [index_width-1:0]       iss_rs1,
  input  logic [index_width-1:0]       iss_rs2,
  output logic                         iss_ready,
  // register-file write port
  output logic                         rf_we,
  output logic [index_width-1:0]       rf_op0,
  output logic [reg_width-1:0]         rf_D,
  // scoreboard and error
  output logic [(1<<index_width)-1:0]  busy,
  output logic                         err
);

  localparam int nreg = 1 << index_width;

  // 1 when the load unit received the most recent grant; reset points at
  // the ALU so the load unit wins the first tie.
  logic                   last_m;
  logic                   a_take;
  logic                   m_take;
  logic                   wb_take;
  logic                   iss_take;
  logic [index_width-1:0] wb_idx;
  logic [reg_width-1:0]   wb_data;
  logic [nreg-1:0]        set_mask;
  logic [nreg-1:0]        clr_mask;

  // Grant one requester per cycle; on a tie, grant the one not granted last.
  always_comb begin
    a_ready = 1'b0;
    m_ready = 1'b0;
    if (rstn) begin
      if (a_valid && m_valid) begin
        a_ready = last_m;
        m_ready = !last_m;
      end else begin
        a_ready = a_valid;
        m_ready = m_valid;
      end
    end
  end

  assign a_take  = a_valid & a_ready;
  assign m_take  = m_valid & m_ready;
  assign wb_take = a_take | m_take;
  assign wb_idx  = m_take ? m_idx  : a_idx;
  assign wb_data = m_take ? m_data : a_data;

  // Issue is allowed only when no operand or destination has a pending
  // writeback; registered busy only, so a clear is visible a cycle later.
  always_comb begin
    iss_ready = 1'b0;
    if (rstn) begin
      iss_ready = !(busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]);
    end
  end

  assign iss_take = iss_valid & iss_ready;

  // One-hot set/clear masks for the scoreboard update.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_take) begin
      set_mask[iss_rd] = 1'b1;
    end
    if (wb_take) begin
      clr_mask[wb_idx] = 1'b1;
    end
  end

  // Scoreboard: clear applied first so a same-index set wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  // Round-robin pointer moves only when a writeback is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_m <= 1'b0;
    end else if (wb_take) begin
      last_m <= m_take;
    end
  end

  // Sticky error: writeback to a register with no pending writeback.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (wb_take && !busy[wb_idx]) begin
      err <= 1'b1;
    end
  end

  // Register-file write port, one cycle after acceptance; address and data
  // hold their last values when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we  <= 1'b0;
      rf_op0 <= '0;
      rf_D   <= '0;
    end else begin
      rf_we <= wb_take;
      if (wb_take) begin
        rf_op0 <= wb_idx;
        rf_D   <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler. Stimulus pushes expected
// register-file writes into a queue; a monitor pops and compares on rf_we.
module tb_regfile_wb_scheduler;

  localparam int iw = 3;
  localparam int rw = 32;

  logic          clk;
  logic          rstn;
  logic          a_valid, a_ready;
  logic [iw-1:0] a_idx;
  logic [rw-1:0] a_data;
  logic          m_valid, m_ready;
  logic [iw-1:0] m_idx;
  logic [rw-1:0] m_data;
  logic          iss_valid, iss_ready;
  logic [iw-1:0] iss_rd, iss_rs1, iss_rs2;
  logic          rf_we;
  logic [iw-1:0] rf_op0;
  logic [rw-1:0] rf_D;
  logic [7:0]    busy;
  logic          err;

  typedef struct packed {
    logic [iw-1:0] idx;
    logic [rw-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  regfile_wb_scheduler #(.index_width(iw), .reg_width(rw)) dut (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_data(m_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_ready(iss_ready),
    .rf_we(rf_we), .rf_op0(rf_op0), .rf_D(rf_D),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [iw-1:0] idx, input logic [rw-1:0] data);
    wb_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [iw-1:0] rd);
    iss_valid = 1'b1; iss_rd = rd; iss_rs1 = rd; iss_rs2 = rd;
    #1 chk("issue_ready", {63'd0, iss_ready}, 64'd1);
    tick();
    iss_valid = 1'b0;
  endtask

  // Monitor: every rf_we pulse must match the oldest expected write.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL rf_we_unexpected: got rf_we=1 op0=%0d D=0x%08h expected rf_we=0", rf_op0, rf_D);
        end else begin
          e = exp_q.pop_front();
          if (rf_op0 !== e.idx || rf_D !== e.data) begin
            n_errors++;
            $display("FAIL rf_write: got op0=%0d D=0x%08h expected op0=%0d D=0x%08h",
                     rf_op0, rf_D, e.idx, e.data);
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    a_valid = 1'b0; a_idx = '0; a_data = '0;
    m_valid = 1'b0; m_idx = '0; m_data = '0;
    iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    tick(); tick();

    // Reset state; readies held low even with requests present.
    a_valid = 1'b1; m_valid = 1'b1;
    #1;
    chk("rst_busy",   {56'd0, busy}, 64'h0);
    chk("rst_err",    {63'd0, err}, 64'd0);
    chk("rst_rf_we",  {63'd0, rf_we}, 64'd0);
    chk("rst_rf_op0", {61'd0, rf_op0}, 64'd0);
    chk("rst_rf_D",   {32'd0, rf_D}, 64'd0);
    chk("rst_ready",  {61'd0, a_ready, m_ready, iss_ready}, 64'd0);
    a_valid = 1'b0; m_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // Tie on idx 2 (ALU) and 5 (load): load first, ALU next cycle.
    issue(3'd2);
    issue(3'd5);
    chk("t2_busy_set", {56'd0, busy}, 64'h24);
    a_valid = 1'b1; a_idx = 3'd2; a_data = 32'h1111_2222;
    m_valid = 1'b1; m_idx = 3'd5; m_data = 32'h5555_6666;
    #1 chk("t2_tie1_grant", {62'd0, a_ready, m_ready}, 64'b01);
    push(3'd5, 32'h5555_6666);
    tick();
    m_valid = 1'b0;
    #1 chk("t2_tie2_grant", {62'd0, a_ready, m_ready}, 64'b10);
    chk("t2_rf_we_1st", {63'd0, rf_we}, 64'd1);
    push(3'd2, 32'h1111_2222);
    tick();
    a_valid = 1'b0;
    #1 chk("t2_rf_we_2nd", {63'd0, rf_we}, 64'd1);
    chk("t2_busy_clr", {56'd0, busy}, 64'h0);
    tick();

    // Issue rd=3, then load writeback to 3.
    issue(3'd3);
    #1 chk("t1_busy_set", {56'd0, busy}, 64'h08);
    m_valid = 1'b1; m_idx = 3'd3; m_data = 32'hDEAD_BEEF;
    #1 chk("t1_m_ready", {62'd0, a_ready, m_ready}, 64'b01);
    push(3'd3, 32'hDEAD_BEEF);
    tick();
    m_valid = 1'b0;
    #1 chk("t1_busy_clr", {56'd0, busy}, 64'h0);
    chk("t1_err", {63'd0, err}, 64'd0);
    tick();

    // Issue stalled on rs1=4; ready only the cycle after the clear.
    issue(3'd4);
    #1 chk("t3_busy_set", {56'd0, busy}, 64'h10);
    iss_valid = 1'b1; iss_rs1 = 3'd4; iss_rs2 = 3'd1; iss_rd = 3'd6;
    #1 chk("t3_stall", {63'd0, iss_ready}, 64'd0);
    tick();
    a_valid = 1'b1; a_idx = 3'd4; a_data = 32'h4444_0004;
    #1 chk("t3_accept_cycle", {62'd0, a_ready, iss_ready}, 64'b10);
    push(3'd4, 32'h4444_0004);
    tick();
    a_valid = 1'b0;
    #1 chk("t3_after_clear", {55'd0, iss_ready, busy}, {55'd0, 1'b1, 8'h00});
    tick();
    iss_valid = 1'b0;
    #1 chk("t3_issued", {56'd0, busy}, 64'h40);
    m_valid = 1'b1; m_idx = 3'd6; m_data = 32'h6666_0006;
    push(3'd6, 32'h6666_0006);
    tick();
    m_valid = 1'b0;
    #1 chk("t3_busy_clr", {56'd0, busy}, 64'h0);
    tick();

    // Writeback to a non-busy register: still written, err sticks.
    chk("t5_err_pre", {63'd0, err}, 64'd0);
    a_valid = 1'b1; a_idx = 3'd1; a_data = 32'h0BAD_F00D;
    push(3'd1, 32'h0BAD_F00D);
    tick();
    a_valid = 1'b0;
    #1 chk("t5_err_set", {63'd0, err}, 64'd1);
    for (int i = 0; i < 10; i++) tick();
    #1 chk("t5_err_held", {63'd0, err}, 64'd1);

    // Same-index issue and writeback on register 7. The issue gate keeps
    // iss_ready low while busy[7] is set, so the collision can only arise
    // with busy[7] clear; the set must still win over the clear.
    iss_valid = 1'b1; iss_rd = 3'd7; iss_rs1 = 3'd0; iss_rs2 = 3'd0;
    m_valid = 1'b1; m_idx = 3'd7; m_data = 32'h7777_0007;
    #1 chk("t4_both_ready", {62'd0, iss_ready, m_ready}, 64'b11);
    push(3'd7, 32'h7777_0007);
    tick();
    iss_valid = 1'b0; m_valid = 1'b0;
    #1 chk("t4_set_wins", {56'd0, busy}, 64'h80);
    tick();

    // Reset the cycle after an acceptance drops the pending write.
    issue(3'd2);
    a_valid = 1'b1; a_idx = 3'd2; a_data = 32'hCAFE_0002;
    @(posedge clk);
    #2;
    a_valid = 1'b0;
    chk("t6_rf_we_pre", {63'd0, rf_we}, 64'd1);
    rstn = 1'b0;
    #1;
    chk("t6_rf_we_rst", {63'd0, rf_we}, 64'd0);
    chk("t6_busy_rst",  {56'd0, busy}, 64'h0);
    chk("t6_err_rst",   {63'd0, err}, 64'd0);
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    issue(3'd3);
    issue(3'd4);
    a_valid = 1'b1; a_idx = 3'd3; a_data = 32'hAAAA_0003;
    m_valid = 1'b1; m_idx = 3'd4; m_data = 32'hBBBB_0004;
    #1 chk("t6_first_tie", {62'd0, a_ready, m_ready}, 64'b01);
    push(3'd4, 32'hBBBB_0004);
    tick();
    m_valid = 1'b0;
    push(3'd3, 32'hAAAA_0003);
    tick();
    a_valid = 1'b0;
    tick();
    #1 chk("t6_busy_end", {56'd0, busy}, 64'h0);
    tick(); tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
